// File: rtl/rectangle128_pkg.sv
// rectangle128_pkg
//   Shared constants and types for the RECTANGLE128 round-key read path.
//   RECT_NUM_KEYS : round keys in one schedule (25 rounds + final whitening)
//   RECT_KEY_W    : width of one round key
//   RECT_ADDR_W   : width of a key-memory address
//   skey_fetch_state_t : state encoding of the key fetch sequencer
package rectangle128_pkg;

    localparam int RECT_NUM_KEYS = 26;
    localparam int RECT_KEY_W    = 64;
    localparam int RECT_ADDR_W   = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SKEY = 2'd1,
        FETCH     = 2'd2,
        DRAIN     = 2'd3
    } skey_fetch_state_t;

endpackage

// File: rtl/rectangle128_skey_buf.sv
// rectangle128_skey_buf
//   Small synchronous FIFO used as the round-key prefetch buffer.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     flush      : drop all contents (takes priority over push/pop)
//     push       : write push_data at the tail
//     push_data  : data to write
//     pop        : remove the head entry (ignored when empty)
//     head       : current head entry (meaningless when empty)
//     empty      : no entries stored
//     count      : number of stored entries
//   Push and pop in the same cycle are allowed, also when full.
module rectangle128_skey_buf #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: head is only looked at when not empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rectangle128_skey_fetch.sv
// rectangle128_skey_fetch
//   Read-side sequencer for the RECTANGLE128 round-key memory. After a Start
//   it walks the stored round keys (ascending for encryption, descending for
//   decryption), prefetches them into a small buffer and hands them to the
//   cipher core one per cycle.
//   Ports:
//     Clk, RstN      : clock, asynchronous active-low reset
//     Start          : one-cycle pulse, begins a sequence (accepted in IDLE only)
//     Encrypt        : sampled with Start; 1 = ascending, 0 = descending
//     skey_ready     : key memory holds a complete schedule
//     RAddr          : registered key-memory read address
//     KeyIn          : key-memory read data, valid RD_LAT cycles after RAddr
//     roundKey       : head-of-buffer round key (0 when no key is valid)
//     roundKeyValid  : roundKey is valid
//     roundIdx       : logical round number of roundKey, always counts up
//     lastKey        : roundKeyValid and roundIdx == NUM_KEYS-1
//     Next           : core consumes roundKey this cycle
//     busy           : sequence in progress
//     done           : one-cycle pulse after the last key was consumed
//     abort          : one-cycle pulse when skey_ready dropped mid-sequence
//     dbg_state      : current sequencer state
//
//   Output handshake: a key is transferred on every rising edge where
//   roundKeyValid=1 and Next=1. roundKey/roundIdx stay stable while
//   roundKeyValid=1 and Next=0. Next is ignored when roundKeyValid=0.
//
//   RD_LAT must be 1..2 and BUF_DEPTH at least RD_LAT+1.
module rectangle128_skey_fetch
    import rectangle128_pkg::*;
#(
    parameter int NUM_KEYS  = RECT_NUM_KEYS,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2
) (
    input  logic                   Clk,
    input  logic                   RstN,
    input  logic                   Start,
    input  logic                   Encrypt,
    input  logic                   skey_ready,
    output logic [RECT_ADDR_W-1:0] RAddr,
    input  logic [RECT_KEY_W-1:0]  KeyIn,
    output logic [RECT_KEY_W-1:0]  roundKey,
    output logic                   roundKeyValid,
    output logic [RECT_ADDR_W-1:0] roundIdx,
    output logic                   lastKey,
    input  logic                   Next,
    output logic                   busy,
    output logic                   done,
    output logic                   abort,
    output skey_fetch_state_t      dbg_state
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [RECT_ADDR_W-1:0] TOP_ADDR = RECT_ADDR_W'(NUM_KEYS - 1);

    skey_fetch_state_t      state;
    skey_fetch_state_t      state_nxt;
    logic                   enc_q;
    logic [RD_LAT-1:0]      pipe;
    logic [RECT_KEY_W-1:0]  buf_head;
    logic                   buf_empty;
    logic [CNT_W-1:0]       buf_count;

    logic                   pop;
    logic                   push;
    logic                   load_first;
    logic                   issue;
    logic                   flush;
    logic                   done_set;
    logic                   abort_set;
    logic                   start_acc;
    logic                   credit_ok;
    logic                   first_dir;
    int                     inflight;
    logic [RECT_ADDR_W-1:0] first_addr;
    logic [RECT_ADDR_W-1:0] next_addr;
    logic [RECT_ADDR_W-1:0] last_addr;

    // ---------------------------------------------------------------
    // Prefetch buffer
    // ---------------------------------------------------------------
    rectangle128_skey_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (RECT_KEY_W)
    ) u_buf (
        .clk       (Clk),
        .rst_n     (RstN),
        .flush     (flush),
        .push      (push),
        .push_data (KeyIn),
        .pop       (pop),
        .head      (buf_head),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign roundKeyValid = !buf_empty;
    assign roundKey      = roundKeyValid ? buf_head : '0;
    assign lastKey       = roundKeyValid && (roundIdx == TOP_ADDR);
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

    assign pop  = Next && roundKeyValid;
    assign push = pipe[RD_LAT-1] && !flush;

    // ---------------------------------------------------------------
    // Address arithmetic
    // ---------------------------------------------------------------
    // In IDLE the direction is not latched yet, so take it from the port.
    assign first_dir  = (state == IDLE) ? Encrypt : enc_q;
    assign first_addr = first_dir ? '0 : TOP_ADDR;
    assign next_addr  = enc_q ? (RAddr + RECT_ADDR_W'(1)) : (RAddr - RECT_ADDR_W'(1));
    assign last_addr  = enc_q ? TOP_ADDR : '0;
    assign start_acc  = (state == IDLE) && Start;

    // ---------------------------------------------------------------
    // Credit: every buffer slot is owned either by a stored key or by a
    // read in flight. A pop this cycle frees a slot in time for a read
    // issued now, which keeps one key per cycle with Next held high.
    // ---------------------------------------------------------------
    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + int'(pipe[i]);
        end
    end

    assign credit_ok = (int'(buf_count) + inflight) < (BUF_DEPTH + int'(pop));

    // ---------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_first = 1'b0;
        issue      = 1'b0;
        flush      = 1'b0;
        done_set   = 1'b0;
        abort_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    if (skey_ready) begin
                        load_first = 1'b1;
                        state_nxt  = FETCH;
                    end else begin
                        state_nxt  = WAIT_SKEY;
                    end
                end
            end
            WAIT_SKEY: begin
                if (skey_ready) begin
                    load_first = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            FETCH: begin
                if (!skey_ready) begin
                    flush     = 1'b1;
                    abort_set = 1'b1;
                    state_nxt = IDLE;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (next_addr == last_addr) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // All reads are issued; the last key popping implies the
                // buffer and pipe are already empty.
                if (!skey_ready) begin
                    flush     = 1'b1;
                    abort_set = 1'b1;
                    state_nxt = IDLE;
                end else if (pop && (roundIdx == TOP_ADDR)) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            RAddr    <= '0;
            enc_q    <= 1'b1;
            roundIdx <= '0;
            done     <= 1'b0;
            abort    <= 1'b0;
        end else begin
            done  <= done_set;
            abort <= abort_set;
            if (start_acc) enc_q <= Encrypt;
            if (load_first)  RAddr <= first_addr;
            else if (issue)  RAddr <= next_addr;
            if (start_acc || abort_set) roundIdx <= '0;
            else if (pop)               roundIdx <= roundIdx + RECT_ADDR_W'(1);
        end
    end

    // Reads-in-flight tracker: bit k set means a read issued k+1 cycles ago.
    if (RD_LAT == 1) begin : g_pipe_1
        always_ff @(posedge Clk or negedge RstN) begin
            if (!RstN)      pipe <= '0;
            else if (flush) pipe <= '0;
            else            pipe <= load_first || issue;
        end
    end else begin : g_pipe_n
        always_ff @(posedge Clk or negedge RstN) begin
            if (!RstN)      pipe <= '0;
            else if (flush) pipe <= '0;
            else            pipe <= {pipe[RD_LAT-2:0], (load_first || issue)};
        end
    end

endmodule

// File: tb/tb_rectangle128_skey_fetch.sv
// tb_rectangle128_skey_fetch
//   Directed bench for the round-key fetch sequencer: encrypt/decrypt walks,
//   backpressure, late schedule, abort/replay, reset and ignored Start.
module tb_rectangle128_skey_fetch;

    localparam int NK        = 26;
    localparam int RD_LAT    = 1;
    localparam int BUF_DEPTH = 2;
    localparam logic [63:0] KEY_BASE = 64'h1111_0000_0000_0000;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        encrypt = 1'b1;
    logic        skey_ready = 1'b0;
    logic [4:0]  raddr;
    logic [63:0] key_in;
    logic [63:0] round_key;
    logic        round_key_valid;
    logic [4:0]  round_idx;
    logic        last_key;
    logic        next = 1'b0;
    logic        busy;
    logic        done;
    logic        abort;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Key memory with one cycle read latency relative to the registered address.
    assign key_in = KEY_BASE + 64'(raddr);

    rectangle128_skey_fetch #(
        .NUM_KEYS  (NK),
        .RD_LAT    (RD_LAT),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .Clk           (clk),
        .RstN          (rst_n),
        .Start         (start),
        .Encrypt       (encrypt),
        .skey_ready    (skey_ready),
        .RAddr         (raddr),
        .KeyIn         (key_in),
        .roundKey      (round_key),
        .roundKeyValid (round_key_valid),
        .roundIdx      (round_idx),
        .lastKey       (last_key),
        .Next          (next),
        .busy          (busy),
        .done          (done),
        .abort         (abort),
        .dbg_state     (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [68:0] exp_q[$];
    logic [68:0] mon_e;
    int checks = 0;
    int errors = 0;
    int pop_count = 0;
    int done_count = 0;
    int abort_count = 0;
    int done_cyc = 0;
    int last_pop_edge = -1;
    int start_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted key is compared against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (round_key_valid && next) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key: got idx %0d key 0x%0h, expected no key", round_idx, round_key);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("round_key", round_key, mon_e[63:0]);
                    check("round_idx", 64'(round_idx), 64'(mon_e[68:64]));
                    check("last_key", 64'(last_key), 64'(mon_e[68:64] == 5'(NK - 1)));
                    if (mon_e[68:64] == 5'(NK - 1)) last_pop_edge = cyc + 1;
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("done_after_last_pop", 64'(cyc), 64'(last_pop_edge));
            end
            if (abort) abort_count++;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic start_run(input logic enc);
        int a;
        @(posedge clk); #1;
        start   = 1'b1;
        encrypt = enc;
        for (int i = 0; i < NK; i++) begin
            a = enc ? i : (NK - 1 - i);
            exp_q.push_back({5'(i), KEY_BASE + 64'(a)});
        end
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  d0;
        logic got;
        d0  = done_count;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #1;
            if (done_count != d0) got = 1'b1;
        end
        check("done_arrives", 64'(got), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_raddr"}, 64'(raddr), 64'(0));
        check({tag, "_round_key"}, round_key, 64'(0));
        check({tag, "_valid"}, 64'(round_key_valid), 64'(0));
        check({tag, "_round_idx"}, 64'(round_idx), 64'(0));
        check({tag, "_last_key"}, 64'(last_key), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_abort"}, 64'(abort), 64'(0));
        check({tag, "_state"}, 64'(dbg_state), 64'(0));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int   rise_cyc;
        int   valid_cyc;
        int   d0;
        logic seen;

        #2;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Encrypt walk, Next held high.
        skey_ready = 1'b1;
        next       = 1'b1;
        start_run(1'b1);
        @(negedge clk);
        check("enc_first_raddr", 64'(raddr), 64'(0));
        check("enc_busy", 64'(busy), 64'(1));
        wait_done(60);
        check("enc_total_cycles", 64'(done_cyc - start_cyc + 1), 64'(NK + RD_LAT + 1));
        check("enc_queue_empty", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        check("enc_done_one_cycle", 64'(done), 64'(0));
        check("enc_busy_after", 64'(busy), 64'(0));

        // Decrypt walk.
        start_run(1'b0);
        @(negedge clk);
        check("dec_first_raddr", 64'(raddr), 64'(NK - 1));
        wait_done(60);
        check("dec_total_cycles", 64'(done_cyc - start_cyc + 1), 64'(NK + RD_LAT + 1));
        check("dec_queue_empty", 64'(exp_q.size()), 64'(0));

        // Backpressure: hold Next low for 10 cycles, then toggle.
        next = 1'b0;
        start_run(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (round_key_valid) seen = 1'b1;
        end
        check("bp_first_valid", 64'(seen), 64'(1));
        repeat (10) @(negedge clk);
        check("bp_raddr_stalled", 64'(raddr), 64'(BUF_DEPTH - 1));
        check("bp_head_key", round_key, KEY_BASE);
        check("bp_head_idx", 64'(round_idx), 64'(0));
        d0 = done_count;
        for (int i = 0; i < 200 && done_count == d0; i++) begin
            @(posedge clk); #1;
            next = ~next;
        end
        next = 1'b1;
        check("bp_done", 64'(done_count - d0), 64'(1));
        check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

        // Late schedule: Start while skey_ready=0.
        skey_ready = 1'b0;
        start_run(1'b1);
        @(negedge clk);
        check("late_busy", 64'(busy), 64'(1));
        check("late_valid", 64'(round_key_valid), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        check("late_raddr_static", 64'(raddr), 64'(NK - 1));
        check("late_state", 64'(dbg_state), 64'(1));
        skey_ready = 1'b1;
        rise_cyc   = cyc;
        valid_cyc  = -1;
        for (int i = 0; i < 10 && valid_cyc < 0; i++) begin
            @(negedge clk);
            if (round_key_valid) valid_cyc = cyc;
        end
        check("late_first_valid_delay", 64'(valid_cyc - rise_cyc), 64'(2));
        wait_done(60);
        check("late_queue_empty", 64'(exp_q.size()), 64'(0));

        // Abort after 7 keys consumed, then replay.
        d0 = done_count;
        start_run(1'b1);
        begin
            int p0;
            p0 = pop_count - 0;
            p0 = pop_count;
            for (int i = 0; i < 100 && (pop_count - p0) < 7; i++) begin
                @(posedge clk); #1;
            end
            next       = 1'b0;
            skey_ready = 1'b0;
            check("abort_consumed", 64'(pop_count - p0), 64'(7));
        end
        check("abort_remaining", 64'(exp_q.size()), 64'(NK - 7));
        @(posedge clk);
        @(negedge clk);
        check("abort_pulse", 64'(abort), 64'(1));
        check("abort_valid", 64'(round_key_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        exp_q.delete();
        @(negedge clk);
        check("abort_one_cycle", 64'(abort), 64'(0));
        check("abort_no_done", 64'(done_count - d0), 64'(0));
        @(posedge clk); #1;
        skey_ready = 1'b1;
        next       = 1'b1;
        start_run(1'b1);
        wait_done(60);
        check("replay_queue_empty", 64'(exp_q.size()), 64'(0));

        // Reset mid-FETCH.
        next = 1'b0;
        start_run(1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Start while busy is ignored.
        next = 1'b1;
        d0   = done_count;
        start_run(1'b1);
        repeat (3) @(posedge clk);
        #1;
        start   = 1'b1;
        encrypt = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(60);
        repeat (40) @(negedge clk);
        check("busy_start_single_done", 64'(done_count - d0), 64'(1));
        check("busy_start_queue_empty", 64'(exp_q.size()), 64'(0));
        check("busy_start_idle", 64'(busy), 64'(0));

        check("total_done_pulses", 64'(done_count), 64'(6));
        check("total_abort_pulses", 64'(abort_count), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
